pin_setter: RTL and testbench
=============================

PIN_SETTER -- requirements
Module: pin_setter

Interface
REQ-001 Parameter FRAME_CYCLES, 2000000, servo PWM frame length in clk cycles (20 ms at 100 MHz).
REQ-002 Parameter REST_CYCLES, 100000, pulse width for the rest position (1 ms).
REQ-003 Parameter RAISE_CYCLES, 200000, pulse width for the raise position (2 ms).
REQ-004 Parameter HOLD_FRAMES, 25, number of frames the raise pulse is held per attempt.
REQ-005 Parameter SETTLE_FRAMES, 5, number of rest frames before pin_state is checked.
REQ-006 Parameter MAX_RETRY, 2, maximum re-attempts after the first attempt.
REQ-007 clk  input  1  system clock, 100 MHz.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  one-cycle request to re-stand knocked pins.
REQ-010 pin_state  input  3  per-pin sensor state, 1 = pin standing, 0 = no pin.
REQ-011 servo  output  3  per-pin servo PWM.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a request completes.
REQ-014 fault  output  3  per-pin latch; 1 = pin still down after all attempts.

Function
REQ-015 A free-running frame counter SHALL count 0..FRAME_CYCLES-1 and then wrap to 0; a frame tick occurs when the counter is 0.
REQ-016 servo[i] SHALL be high while counter < width[i]; width[i] SHALL update only on a frame tick, so no truncated or stretched pulses are emitted.
REQ-017 width[i] SHALL be RAISE_CYCLES when the state is RAISE and mask[i]=1; otherwise it SHALL be REST_CYCLES.
REQ-018 States SHALL be IDLE, RAISE, SETTLE, CHECK, DONE.
REQ-019 IDLE + start SHALL latch mask = ~pin_state, clear fault and the retry count, and go to RAISE; if mask = 0 it SHALL go to DONE instead.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 RAISE SHALL go to SETTLE after HOLD_FRAMES frame ticks.
REQ-022 SETTLE SHALL go to CHECK after SETTLE_FRAMES frame ticks.
REQ-023 CHECK (one cycle) SHALL set mask <= mask & ~pin_state, then:
  - mask still nonzero and retry < MAX_RETRY: retry++, go to RAISE;
  - mask still nonzero, retries exhausted: fault <= mask, go to DONE;
  - mask zero: go to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 Pins already standing at start SHALL never receive a raise pulse.
REQ-026 Pins that come up between attempts SHALL be dropped from later attempts.
REQ-027 The retry counter SHALL be wide enough to hold MAX_RETRY with no wrap.

Reset
REQ-028 rst SHALL force state IDLE, frame counter 0, mask 0, retry 0, fault 0, done 0, busy 0, servo 0, and all widths to REST_CYCLES.
REQ-029 rst during RAISE SHALL drive servo low immediately and abort the request with no done pulse.

Configuration
REQ-030 With PIN_SETTER_RETRY_EN defined, retry SHALL behave as in REQ-023.
REQ-031 Without PIN_SETTER_RETRY_EN, CHECK SHALL always go to DONE with fault <= the remaining mask, i.e. MAX_RETRY is treated as 0.

Structure
REQ-032 Package pin_pkg SHALL hold the state enum, NUM_PINS=3, and the default pulse and frame constants.
REQ-033 Sub-module servo_pwm_gen SHALL hold the frame counter, frame tick, and per-pin width registers with boundary-only updates.

Verification
Bench parameters: FRAME_CYCLES=200, REST_CYCLES=10, RAISE_CYCLES=20, HOLD_FRAMES=2, SETTLE_FRAMES=1, MAX_RETRY=2, retry enabled.
REQ-034 pin_state=3'b111, start -> done on the next cycle, busy 1 cycle, no 20-cycle pulses, fault=000.
REQ-035 pin_state=3'b010, start, pins set to 111 during SETTLE -> servo[0] and servo[2] give 2 pulses of 20 cycles, servo[1] only 10-cycle pulses, done, fault=000.
REQ-036 pin_state=3'b011 held -> 3 attempts on servo[2] only, done, fault=3'b100.
REQ-037 start asserted during RAISE -> ignored; mask unchanged and exactly one done pulse.
REQ-038 rst asserted mid-pulse in RAISE -> servo=000 in the same cycle, busy=0, no done; a new start then works normally.
REQ-039 Retry disabled, pin_state=3'b011 held -> one attempt, fault=3'b100 after about 3 frames.

Source files
------------

// File: rtl/pin_pkg.sv
// Package: pin_pkg
// Shared definitions for the pin setter block.
//   - NUM_PINS             : number of pin positions served (one servo each)
//   - *_DEF                : default frame, pulse and attempt constants (100 MHz clk)
//   - state_t              : controller state encoding
//   - pin_dbg_t            : controller debug snapshot exported on the bus interface
//   - cnt_bits()           : width needed to hold a value 0..max_val without wrap
package pin_pkg;

  localparam int NUM_PINS = 3;

  localparam int FRAME_CYCLES_DEF  = 2000000; // 20 ms frame
  localparam int REST_CYCLES_DEF   = 100000;  // 1 ms pulse, rest position
  localparam int RAISE_CYCLES_DEF  = 200000;  // 2 ms pulse, raise position
  localparam int HOLD_FRAMES_DEF   = 25;
  localparam int SETTLE_FRAMES_DEF = 5;
  localparam int MAX_RETRY_DEF     = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAISE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    state_t              state;
    logic [NUM_PINS-1:0] mask;
    logic [7:0]          retry;
    logic [7:0]          frames;
  } pin_dbg_t;

  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pin_setter_if.sv
// Interface: pin_setter_if
// Groups the request/status signals of the pin setter.
//   start     : request to re-stand knocked pins
//   pin_state : per-pin sensor, 1 = pin standing
//   servo     : per-pin servo PWM
//   busy      : controller not idle
//   done      : request completed
//   fault     : per-pin latch of pins still down after all attempts
//   dbg       : controller state snapshot (state, mask, retry, frame count)
//
// Handshake: start is a single-cycle request and is only sampled while the
// controller is idle (busy = 0); a start seen while busy is dropped, there is
// no back-pressure. busy rises the cycle after an accepted start and stays
// high through the cycle in which done pulses for exactly one cycle; fault is
// valid from that done cycle until the next accepted start.
interface pin_setter_if;
  import pin_pkg::*;

  logic                start;
  logic [NUM_PINS-1:0] pin_state;
  logic [NUM_PINS-1:0] servo;
  logic                busy;
  logic                done;
  logic [NUM_PINS-1:0] fault;
  pin_dbg_t            dbg;

  modport master (
    output start, pin_state,
    input  servo, busy, done, fault, dbg
  );

  modport slave (
    input  start, pin_state,
    output servo, busy, done, fault, dbg
  );

endinterface

// File: rtl/pin_setter_servo_pwm_gen.sv
// Module: servo_pwm_gen
// Free-running servo frame generator with one pulse-width register per pin.
//   clk, rst   : clock, asynchronous active-high reset
//   raise_req  : per-pin request for the raise pulse width in the next frame
//   frame_tick : high while the frame counter is 0 (first cycle of a frame)
//   servo      : per-pin registered PWM, high while counter < width
// Widths are only loaded on the frame tick, so every emitted pulse is a whole
// REST_CYCLES or RAISE_CYCLES pulse.
module servo_pwm_gen
  import pin_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int REST_CYCLES  = REST_CYCLES_DEF,
  parameter int RAISE_CYCLES = RAISE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] raise_req,
  output logic                frame_tick,
  output logic [NUM_PINS-1:0] servo
);

  localparam int WMAX = (RAISE_CYCLES > REST_CYCLES) ? RAISE_CYCLES : REST_CYCLES;
  localparam int TMAX = ((FRAME_CYCLES - 1) > WMAX) ? (FRAME_CYCLES - 1) : WMAX;
  // Counter and widths share one width so the compare is width-matched.
  localparam int CW = cnt_bits(TMAX);

  localparam logic [CW-1:0] LAST    = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] REST_W  = CW'(REST_CYCLES);
  localparam logic [CW-1:0] RAISE_W = CW'(RAISE_CYCLES);

  logic [CW-1:0]                cnt;
  logic [NUM_PINS-1:0][CW-1:0]  width_q;

  assign frame_tick = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // On the tick cycle the compare still sees the previous width; since every
  // width is at least one cycle the output is high at count 0 either way, so
  // the pulse length equals the newly loaded width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        width_q[i] <= REST_W;
      end
      servo <= '0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (frame_tick) begin
          width_q[i] <= raise_req[i] ? RAISE_W : REST_W;
        end
        servo[i] <= (cnt < width_q[i]);
      end
    end
  end

endmodule

// File: rtl/pin_setter.sv
// Module: pin_setter
// Re-stands knocked bowling pins by raising their servos for a number of
// frames, letting them settle, checking the sensors and retrying stragglers.
//   clk, rst : clock (100 MHz), asynchronous active-high reset
//   bus      : pin_setter_if.slave (start, pin_state in; servo, busy, done,
//              fault, dbg out)
// Build option: define PIN_SETTER_RETRY_EN to enable re-attempts (up to
// MAX_RETRY after the first attempt). Without it every request makes a
// single attempt and any pin still down is latched into fault.
module pin_setter
  import pin_pkg::*;
#(
  parameter int FRAME_CYCLES  = FRAME_CYCLES_DEF,
  parameter int REST_CYCLES   = REST_CYCLES_DEF,
  parameter int RAISE_CYCLES  = RAISE_CYCLES_DEF,
  parameter int HOLD_FRAMES   = HOLD_FRAMES_DEF,
  parameter int SETTLE_FRAMES = SETTLE_FRAMES_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic         clk,
  input  logic         rst,
  pin_setter_if.slave  bus
);

  localparam int RW   = cnt_bits(MAX_RETRY);
  localparam int FMAX = (HOLD_FRAMES > SETTLE_FRAMES) ? HOLD_FRAMES : SETTLE_FRAMES;
  localparam int FW   = cnt_bits(FMAX);

  localparam logic [FW-1:0] HOLD_LAST   = FW'(HOLD_FRAMES - 1);
  localparam logic [FW-1:0] SETTLE_LAST = FW'(SETTLE_FRAMES - 1);

  state_t              state;
  logic [NUM_PINS-1:0] mask;
  logic [NUM_PINS-1:0] fault_q;
  logic [NUM_PINS-1:0] remain;
  logic [NUM_PINS-1:0] raise_req;
  logic [NUM_PINS-1:0] servo_w;
  logic [RW-1:0]       retry;
  logic [FW-1:0]       frames;
  logic                busy_q;
  logic                done_q;
  logic                frame_tick;
  logic                retry_ok;

  // Pins still down once the current attempt has settled.
  assign remain = mask & ~bus.pin_state;

  // Only pins in the mask are ever raised, so standing pins never see a
  // raise pulse and pins that came up are dropped at the next check.
  assign raise_req = (state == S_RAISE) ? mask : '0;

`ifdef PIN_SETTER_RETRY_EN
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  assign retry_ok = (retry < RETRY_MAX);
`else
  assign retry_ok = 1'b0;
`endif

  servo_pwm_gen #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .REST_CYCLES  (REST_CYCLES),
    .RAISE_CYCLES (RAISE_CYCLES)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .raise_req  (raise_req),
    .frame_tick (frame_tick),
    .servo      (servo_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mask    <= '0;
      fault_q <= '0;
      retry   <= '0;
      frames  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mask    <= ~bus.pin_state;
            fault_q <= '0;
            retry   <= '0;
            frames  <= '0;
            busy_q  <= 1'b1;
            if (bus.pin_state == '1) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_RAISE;
            end
          end
        end

        S_RAISE: begin
          if (frame_tick) begin
            if (frames == HOLD_LAST) begin
              frames <= '0;
              state  <= S_SETTLE;
            end else begin
              frames <= frames + FW'(1);
            end
          end
        end

        S_SETTLE: begin
          if (frame_tick) begin
            if (frames == SETTLE_LAST) begin
              frames <= '0;
              state  <= S_CHECK;
            end else begin
              frames <= frames + FW'(1);
            end
          end
        end

        S_CHECK: begin
          mask <= remain;
          if (remain == '0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else if (retry_ok) begin
            retry <= retry + RW'(1);
            state <= S_RAISE;
          end else begin
            fault_q <= remain;
            state   <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.servo      = servo_w;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.dbg.state  = state;
  assign bus.dbg.mask   = mask;
  assign bus.dbg.retry  = 8'(retry);
  assign bus.dbg.frames = 8'(frames);

endmodule

// File: tb/tb_pin_setter.sv
// Testbench: tb_pin_setter
// Drives pin_setter with short frames and checks pulse counts, done/busy
// timing and fault latching against a request-level reference model.
// Follows PIN_SETTER_RETRY_EN: the model allows MAX_RETRY re-attempts only
// when the macro is defined.
module tb_pin_setter;
  import pin_pkg::*;

  localparam int FRAME  = 200;
  localparam int REST   = 10;
  localparam int RAISE  = 20;
  localparam int HOLD   = 2;
  localparam int SETTLE = 1;
  localparam int MAXR   = 2;
`ifdef PIN_SETTER_RETRY_EN
  localparam int EFF_RETRY = MAXR;
`else
  localparam int EFF_RETRY = 0;
`endif

  logic clk;
  logic rst;
  pin_setter_if bus();

  pin_setter #(
    .FRAME_CYCLES  (FRAME),
    .REST_CYCLES   (REST),
    .RAISE_CYCLES  (RAISE),
    .HOLD_FRAMES   (HOLD),
    .SETTLE_FRAMES (SETTLE),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  int run_len[3]   = '{0, 0, 0};
  int raise_cnt[3] = '{0, 0, 0};
  int bad_cnt      = 0;
  int done_cnt     = 0;

  int base_raise[3];
  int done_base;
  int exp_raise[3];
  logic [2:0] exp_fault;

  // Pulse monitor: every completed high run must be REST or RAISE long.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) run_len[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.servo[i]) begin
          run_len[i] = run_len[i] + 1;
        end else if (run_len[i] != 0) begin
          if (run_len[i] == RAISE) raise_cnt[i] = raise_cnt[i] + 1;
          else if (run_len[i] != REST) bad_cnt = bad_cnt + 1;
          run_len[i] = 0;
        end
      end
      if (bus.done) done_cnt = done_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  // ps0: sensors at start; ups[3a+:3]: pins that come up after attempt a.
  task automatic model(input logic [2:0] ps0, input logic [8:0] ups);
    logic [2:0] ps;
    logic [2:0] need;
    ps   = ps0;
    need = ~ps0;
    for (int i = 0; i < 3; i++) exp_raise[i] = 0;
    for (int a = 0; a <= EFF_RETRY && need != 3'b000; a++) begin
      for (int i = 0; i < 3; i++) if (need[i]) exp_raise[i] += HOLD;
      ps   = ps | ups[a*3 +: 3];
      need = need & ~ps;
    end
    exp_fault = need;
  endtask

  // ---------------- driver tasks ----------------
  task automatic snap();
    for (int i = 0; i < 3; i++) base_raise[i] = raise_cnt[i];
    done_base = done_cnt;
  endtask

  task automatic pulse_start(input logic [2:0] ps);
    @(posedge clk); #1;
    bus.pin_state = ps;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  // Runs one request, raising pins after each attempt's raise pulses end.
  task automatic do_request(input logic [2:0] ps0, input logic [8:0] ups, output bit to);
    logic [2:0] ps;
    logic [2:0] need;
    int a;
    int cum;
    int seen;
    ps   = ps0;
    need = ~ps0;
    a    = 0;
    cum  = HOLD * $countones(need);
    snap();
    pulse_start(ps0);
    to = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (done_cnt != done_base) begin
        to = 1'b0;
        break;
      end
      seen = 0;
      for (int i = 0; i < 3; i++) seen += raise_cnt[i] - base_raise[i];
      if (need != 3'b000 && a <= EFF_RETRY && seen >= cum) begin
        ps            = ps | ups[a*3 +: 3];
        bus.pin_state = ps;
        need          = need & ~ps;
        a++;
        cum += HOLD * $countones(need);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pin_state = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.servo !== 3'b000) begin bad++; $display("FAIL reset_servo got=%b exp=000", bus.servo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.fault !== 3'b000) begin bad++; $display("FAIL reset_fault got=%b exp=000", bus.fault); end
    total++; if (bus.dbg.state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg.state, S_IDLE); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stuck_pin();
    bit to;
    model(3'b011, 9'b0);
    do_request(3'b011, 9'b0, to);
    repeat (5) @(posedge clk); #1;
    total++; if (to) begin bad++; $display("FAIL stuck_timeout got=no_done exp=done"); end
    total++; if (bus.fault !== exp_fault) begin bad++; $display("FAIL stuck_fault got=%b exp=%b", bus.fault, exp_fault); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (raise_cnt[i] - base_raise[i] !== exp_raise[i]) begin
        bad++; $display("FAIL stuck_raise pin%0d got=%0d exp=%0d", i, raise_cnt[i] - base_raise[i], exp_raise[i]);
      end
    end
    total++; if (done_cnt - done_base !== 1) begin bad++; $display("FAIL stuck_done_count got=%0d exp=1", done_cnt - done_base); end
  endtask

  task automatic test_all_standing();
    model(3'b111, 9'b0);
    snap();
    pulse_start(3'b111);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL stand_done got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stand_busy got=%b exp=1", bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stand_done_end got=%b exp=0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stand_busy_end got=%b exp=0", bus.busy); end
    total++; if (bus.fault !== exp_fault) begin bad++; $display("FAIL stand_fault got=%b exp=%b", bus.fault, exp_fault); end
    repeat (450) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (raise_cnt[i] - base_raise[i] !== exp_raise[i]) begin
        bad++; $display("FAIL stand_raise pin%0d got=%0d exp=%0d", i, raise_cnt[i] - base_raise[i], exp_raise[i]);
      end
    end
    total++; if (done_cnt - done_base !== 1) begin bad++; $display("FAIL stand_done_count got=%0d exp=1", done_cnt - done_base); end
  endtask

  task automatic test_partial_rise();
    bit to;
    model(3'b010, 9'b000_000_111);
    do_request(3'b010, 9'b000_000_111, to);
    repeat (5) @(posedge clk); #1;
    total++; if (to) begin bad++; $display("FAIL partial_timeout got=no_done exp=done"); end
    total++; if (bus.fault !== exp_fault) begin bad++; $display("FAIL partial_fault got=%b exp=%b", bus.fault, exp_fault); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (raise_cnt[i] - base_raise[i] !== exp_raise[i]) begin
        bad++; $display("FAIL partial_raise pin%0d got=%0d exp=%0d", i, raise_cnt[i] - base_raise[i], exp_raise[i]);
      end
    end
    total++; if (bad_cnt !== 0) begin bad++; $display("FAIL partial_pulse_len got=%0d bad pulses exp=0", bad_cnt); end
  endtask

  task automatic test_start_during_raise();
    bit ok1;
    bit ok2;
    bit ok3;
    model(3'b101, 9'b000_000_111);
    snap();
    pulse_start(3'b101);
    ok1 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #2;
      if (raise_cnt[1] - base_raise[1] >= 1) begin ok1 = 1'b1; break; end
    end
    // Second start while raising, with sensors that would change the mask.
    pulse_start(3'b000);
    bus.pin_state = 3'b101;
    ok2 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #2;
      if (raise_cnt[1] - base_raise[1] >= 2) begin ok2 = 1'b1; break; end
    end
    bus.pin_state = 3'b111;
    ok3 = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (done_cnt != done_base) begin ok3 = 1'b1; break; end
    end
    repeat (400) @(posedge clk); #1;
    total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL ignore_timeout got=%b%b%b exp=111", ok1, ok2, ok3); end
    total++; if (done_cnt - done_base !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - done_base); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (raise_cnt[i] - base_raise[i] !== exp_raise[i]) begin
        bad++; $display("FAIL ignore_raise pin%0d got=%0d exp=%0d", i, raise_cnt[i] - base_raise[i], exp_raise[i]);
      end
    end
    total++; if (bus.fault !== exp_fault) begin bad++; $display("FAIL ignore_fault got=%b exp=%b", bus.fault, exp_fault); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid_raise();
    bit seen;
    bit to;
    snap();
    pulse_start(3'b000);
    seen = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #2;
      if (run_len[0] >= 15) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_no_raise got=0 exp=1"); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.servo !== 3'b000) begin bad++; $display("FAIL rstmid_servo got=%b exp=000", bus.servo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    repeat (2) @(posedge clk); #3;
    rst = 1'b0;
    repeat (300) @(posedge clk); #1;
    total++; if (done_cnt - done_base !== 0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0", done_cnt - done_base); end
    // A fresh request after the abort behaves normally.
    model(3'b001, 9'b000_000_111);
    do_request(3'b001, 9'b000_000_111, to);
    repeat (5) @(posedge clk); #1;
    total++; if (to) begin bad++; $display("FAIL rstmid_retry_timeout got=no_done exp=done"); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (raise_cnt[i] - base_raise[i] !== exp_raise[i]) begin
        bad++; $display("FAIL rstmid_raise pin%0d got=%0d exp=%0d", i, raise_cnt[i] - base_raise[i], exp_raise[i]);
      end
    end
    total++; if (bus.fault !== exp_fault) begin bad++; $display("FAIL rstmid_fault got=%b exp=%b", bus.fault, exp_fault); end
  endtask

  task automatic test_random();
    logic [2:0] ps0;
    logic [8:0] ups;
    bit to;
    for (int k = 0; k < 6; k++) begin
      ps0 = 3'($urandom_range(0, 7));
      ups = '0;
      for (int a = 0; a < 3; a++) begin
        if ($urandom_range(0, 1) == 1) ups[a*3 +: 3] = 3'($urandom_range(0, 7));
      end
      repeat ($urandom_range(0, FRAME - 1)) @(posedge clk);
      model(ps0, ups);
      do_request(ps0, ups, to);
      repeat (5) @(posedge clk); #1;
      total++; if (to) begin bad++; $display("FAIL rand%0d_timeout got=no_done exp=done", k); end
      total++; if (bus.fault !== exp_fault) begin bad++; $display("FAIL rand%0d_fault ps=%b ups=%b got=%b exp=%b", k, ps0, ups, bus.fault, exp_fault); end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (raise_cnt[i] - base_raise[i] !== exp_raise[i]) begin
          bad++; $display("FAIL rand%0d_raise pin%0d got=%0d exp=%0d", k, i, raise_cnt[i] - base_raise[i], exp_raise[i]);
        end
      end
      total++; if (done_cnt - done_base !== 1) begin bad++; $display("FAIL rand%0d_done_count got=%0d exp=1", k, done_cnt - done_base); end
    end
    total++; if (bad_cnt !== 0) begin bad++; $display("FAIL rand_pulse_len got=%0d bad pulses exp=0", bad_cnt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stuck_pin();
    test_all_standing();
    test_partial_rise();
    test_start_during_raise();
    test_reset_mid_raise();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
